dcache_controller: RTL

- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits directly downstream of the pipeline's MEM stage and replaces the single-cycle data memory path.
- The MEM stage presents load/store requests; the block answers hits in the same cycle and stalls the pipeline on misses.
- Misses are serviced over a line-wide handshake to off-chip data memory.

---
 rtl/dcache_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// dcache_controller
// Direct-mapped, write-back, write-allocate L1 data cache controller placed
// behind the MEM stage. Hits are answered combinationally in the same cycle;
// misses stall the pipeline while whole lines move over a level/ack
// handshake to off-chip memory.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   cpu_req_i    access request from the MEM stage
//   cpu_we_i     1 = store, 0 = load
//   cpu_addr_i   byte address (bits [1:0] ignored)
//   cpu_data_i   store data
//   cpu_data_o   load data (zero unless an idle load hit)
//   cpu_stall_o  pipeline stall request
//   mem_req_o    memory request level (registered)
//   mem_we_o     1 = line write-back, 0 = line fetch (registered)
//   mem_addr_o   line-aligned memory address (registered)
//   mem_data_o   write-back line data (registered)
//   mem_data_i   fetched line data
//   mem_ack_i    one-cycle completion pulse from memory
module dcache_controller #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_BITS  = 256,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [MEM_ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]           cpu_data_i,
  output logic [31:0]           cpu_data_o,
  output logic                  cpu_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [LINE_BITS-1:0]  mem_data_o,
  input  logic [LINE_BITS-1:0]  mem_data_i,
  input  logic                  mem_ack_i
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WORD_W = OFF_W - 2;
  localparam int TAG_W  = MEM_ADDR_W - IDX_W - OFF_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // The missing line's tag/index are latched so that a refill still lands in
  // the right place even if the CPU drops its request mid-miss.
  logic [TAG_W-1:0]      missTag_q;
  logic [IDX_W-1:0]      missIdx_q;
  logic                  memReq_q, memWe_q;
  logic [MEM_ADDR_W-1:0] memAddr_q;
  logic [LINE_BITS-1:0]  memData_q;

  logic [IDX_W-1:0]  reqIdx;
  logic [TAG_W-1:0]  reqTag;
  logic [WORD_W-1:0] reqWord;
  logic [OFF_W+2:0]  wordBase;
  logic              hit, idleHit, idleMiss, victimDirty, fillDone;
  logic              unusedAddrBits;

  assign reqIdx   = cpu_addr_i[OFF_W +: IDX_W];
  assign reqTag   = cpu_addr_i[MEM_ADDR_W-1 -: TAG_W];
  assign reqWord  = cpu_addr_i[2 +: WORD_W];
  assign wordBase = {reqWord, 5'd0};
  assign unusedAddrBits = ^cpu_addr_i[1:0];

  assign hit         = cpu_req_i & valid_q[reqIdx] & (tag_q[reqIdx] == reqTag);
  assign idleHit     = (state_q == IDLE) & hit;
  assign idleMiss    = (state_q == IDLE) & cpu_req_i & ~hit;
  assign victimDirty = valid_q[reqIdx] & dirty_q[reqIdx];
  // A reset arriving together with the last ack must not install the line.
  assign fillDone    = (state_q == ALLOCATE) & mem_ack_i & ~rst_i;

  assign cpu_stall_o = cpu_req_i & ~idleHit;
  assign cpu_data_o  = (idleHit & ~cpu_we_i) ? data_q[reqIdx][wordBase +: 32] : 32'd0;
  assign mem_req_o   = memReq_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_data_o  = memData_q;

  // Next-state logic; memory acks outside the two transfer states are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (idleMiss) state_d = victimDirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM and registered memory-side outputs. The request and write-enable are
  // derived from the next state so they drop in the cycle after the final ack
  // and stay high across the write-back to fetch handover.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      memReq_q  <= 1'b0;
      memWe_q   <= 1'b0;
      memAddr_q <= '0;
      memData_q <= '0;
      missTag_q <= '0;
      missIdx_q <= '0;
    end else begin
      state_q  <= state_d;
      memReq_q <= (state_d != IDLE);
      memWe_q  <= (state_d == WRITEBACK);
      if (idleMiss) begin
        missTag_q <= reqTag;
        missIdx_q <= reqIdx;
        if (victimDirty) begin
          memAddr_q <= {tag_q[reqIdx], reqIdx, {OFF_W{1'b0}}};
          memData_q <= data_q[reqIdx];
        end else begin
          memAddr_q <= {reqTag, reqIdx, {OFF_W{1'b0}}};
        end
      end else if ((state_q == WRITEBACK) && mem_ack_i) begin
        memAddr_q <= {missTag_q, missIdx_q, {OFF_W{1'b0}}};
      end
    end
  end

  // Line status bits. A store hit marks the line dirty; a completed fill
  // installs it clean (a pending store then merges on the following hit).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (idleHit && cpu_we_i) begin
      dirty_q[reqIdx] <= 1'b1;
    end else if (fillDone) begin
      valid_q[missIdx_q] <= 1'b1;
      dirty_q[missIdx_q] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; their contents only matter once the
  // corresponding valid bit is set.
  always_ff @(posedge clk_i) begin
    if (!rst_i && idleHit && cpu_we_i) begin
      data_q[reqIdx][wordBase +: 32] <= cpu_data_i;
    end else if (fillDone) begin
      data_q[missIdx_q] <= mem_data_i;
      tag_q[missIdx_q]  <= missTag_q;
    end
  end

endmodule
